// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous memory between an instruction-fetch port and a load/store port.
// Data wins by default; a saturating starvation counter forces a fetch grant after STARVE_MAX denials.
`timescale 1ns/1ps
module mem_port_arbiter #(
    parameter int WIDTH      = 32,
    parameter int ADDRSIZE   = 12,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hold,
    input  logic                if_req,
    input  logic [ADDRSIZE-1:0] if_addr,
    output logic                if_gnt,
    output logic [0:WIDTH-1]    if_rdata,
    output logic                if_valid,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDRSIZE-1:0] d_addr,
    input  logic [0:WIDTH-1]    d_wdata,
    output logic                d_gnt,
    output logic [0:WIDTH-1]    d_rdata,
    output logic                d_valid,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDRSIZE-1:0] mem_addr,
    output logic [0:WIDTH-1]    mem_wdata,
    input  logic [0:WIDTH-1]    mem_rdata,
    output logic                busy
);
    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

    logic [CW-1:0]       cnt_q, cnt_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDRSIZE-1:0] mem_addr_q, mem_addr_d;
    logic [0:WIDTH-1]    mem_wdata_q, mem_wdata_d;
    // Issue-stage read owner tags, one per requester; they shift into the valids next cycle.
    logic                iss_if_q, iss_if_d;
    logic                iss_d_q, iss_d_d;
    logic                if_valid_q, if_valid_d;
    logic                d_valid_q, d_valid_d;
    logic                busy_q, busy_d;

    logic starved;
    logic grant_ok;

    always_comb begin
        starved  = if_req && (cnt_q == CNT_MAX);
        grant_ok = !rst && !hold;
        if_gnt   = grant_ok && if_req && (starved || !d_req);
        d_gnt    = grant_ok && d_req && !starved;

        // Hold freezes the starvation count so a halted CPU does not bank priority.
        cnt_d = cnt_q;
        if (!hold) begin
            if (!if_req || if_gnt) begin
                cnt_d = '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        mem_en_d    = if_gnt || d_gnt;
        mem_we_d    = d_gnt && d_we;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (d_gnt) begin
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
        end else if (if_gnt) begin
            mem_addr_d  = if_addr;
        end

        iss_if_d   = if_gnt;
        iss_d_d    = d_gnt && !d_we;
        if_valid_d = iss_if_q;
        d_valid_d  = iss_d_q;
        busy_d     = mem_en_d || if_valid_d || d_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            iss_if_q    <= 1'b0;
            iss_d_q     <= 1'b0;
            if_valid_q  <= 1'b0;
            d_valid_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            iss_if_q    <= iss_if_d;
            iss_d_q     <= iss_d_d;
            if_valid_q  <= if_valid_d;
            d_valid_q   <= d_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_valid  = if_valid_q;
    assign d_valid   = d_valid_q;
    assign busy      = busy_q;
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table for grant/issue/return timing plus hold and reset sequences.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst, hold, if_req, d_req, d_we;
    logic [11:0] if_addr, d_addr, mem_addr;
    logic [0:31] d_wdata, if_rdata, d_rdata, mem_wdata, mem_rdata;
    logic        if_gnt, if_valid, d_gnt, d_valid, mem_en, mem_we, busy;

    logic [0:31] mem [0:4095];
    logic        mem_load;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.WIDTH(32), .ADDRSIZE(12), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst), .hold(hold),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    // Single-port synchronous memory: read data appears the cycle after a read mem_en cycle.
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 4096; i++)
                mem[i] <= (i == 5) ? 32'hDEADBEEF : (32'hA5000000 | 32'(i));
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    typedef struct {
        logic        rst, hold, if_req, d_req, d_we;
        logic [11:0] if_addr, d_addr;
        logic [31:0] d_wdata;
        logic        e_if_gnt, e_d_gnt, e_mem_en, e_mem_we;
        logic [11:0] e_mem_addr;
        logic [31:0] e_mem_wdata;
        logic        e_if_valid, e_d_valid, e_busy;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs[$];

    // in = {rst,hold,if_req,d_req,d_we}; g = {if_gnt,d_gnt,mem_en,mem_we}; v = {if_valid,d_valid,busy}
    task automatic add(input logic [4:0] in, input logic [11:0] ia, input logic [11:0] da,
                       input logic [31:0] wd, input logic [3:0] g, input logic [11:0] ma,
                       input logic [31:0] mwd, input logic [2:0] v, input logic [31:0] rd);
        vec_t t;
        {t.rst, t.hold, t.if_req, t.d_req, t.d_we} = in;
        t.if_addr = ia; t.d_addr = da; t.d_wdata = wd;
        {t.e_if_gnt, t.e_d_gnt, t.e_mem_en, t.e_mem_we} = g;
        t.e_mem_addr = ma; t.e_mem_wdata = mwd;
        {t.e_if_valid, t.e_d_valid, t.e_busy} = v;
        t.e_rdata = rd;
        vecs.push_back(t);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic r, input logic h, input logic ir, input logic [11:0] ia,
                          input logic dr, input logic dw, input logic [11:0] da, input logic [31:0] wd);
        rst = r; hold = h; if_req = ir; if_addr = ia;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = wd;
    endtask

    task automatic run_vec(input int idx, input vec_t t);
        set_in(t.rst, t.hold, t.if_req, t.if_addr, t.d_req, t.d_we, t.d_addr, t.d_wdata);
        @(negedge clk);
        chk($sformatf("v%0d.if_gnt", idx),   32'(if_gnt),   32'(t.e_if_gnt));
        chk($sformatf("v%0d.d_gnt", idx),    32'(d_gnt),    32'(t.e_d_gnt));
        chk($sformatf("v%0d.mem_en", idx),   32'(mem_en),   32'(t.e_mem_en));
        chk($sformatf("v%0d.mem_we", idx),   32'(mem_we),   32'(t.e_mem_we));
        if (t.e_mem_en) chk($sformatf("v%0d.mem_addr", idx), 32'(mem_addr), 32'(t.e_mem_addr));
        if (t.e_mem_we) chk($sformatf("v%0d.mem_wdata", idx), mem_wdata, t.e_mem_wdata);
        chk($sformatf("v%0d.if_valid", idx), 32'(if_valid), 32'(t.e_if_valid));
        chk($sformatf("v%0d.d_valid", idx),  32'(d_valid),  32'(t.e_d_valid));
        chk($sformatf("v%0d.busy", idx),     32'(busy),     32'(t.e_busy));
        if (t.e_if_valid) chk($sformatf("v%0d.if_rdata", idx), if_rdata, t.e_rdata);
        if (t.e_d_valid)  chk($sformatf("v%0d.d_rdata", idx),  d_rdata,  t.e_rdata);
        $display("vec %0d: in=%b%b%b%b%b gnt if/d=%b%b mem_en=%b we=%b addr=%03h valid if/d=%b%b busy=%b",
                 idx, t.rst, t.hold, t.if_req, t.d_req, t.d_we, if_gnt, d_gnt,
                 mem_en, mem_we, mem_addr, if_valid, d_valid, busy);
        tick();
    endtask

    initial begin
        mem_load = 1'b1;
        set_in(1'b1, 1'b0, 1'b1, 12'h000, 1'b1, 1'b0, 12'h000, 32'h0);
        tick();
        mem_load = 1'b0;

        // Reset with both requesting
        add(5'b10110, 12'h000, 12'h000, 0, 4'b0000, 0, 0, 3'b000, 0);
        add(5'b10110, 12'h000, 12'h000, 0, 4'b0000, 0, 0, 3'b000, 0);
        // Single fetch read
        add(5'b00100, 12'h005, 12'h000, 0, 4'b1000, 0,       0, 3'b000, 0);
        add(5'b00000, 12'h000, 12'h000, 0, 4'b0010, 12'h005, 0, 3'b001, 0);
        add(5'b00000, 12'h000, 12'h000, 0, 4'b0000, 0,       0, 3'b101, 32'hDEADBEEF);
        add(5'b00000, 12'h000, 12'h000, 0, 4'b0000, 0,       0, 3'b000, 0);
        // Starvation: data read held, fetch held; fetch wins every fifth cycle
        add(5'b00110, 12'h007, 12'h030, 0, 4'b0100, 0,       0, 3'b000, 0);
        add(5'b00110, 12'h007, 12'h030, 0, 4'b0110, 12'h030, 0, 3'b001, 0);
        add(5'b00110, 12'h007, 12'h030, 0, 4'b0110, 12'h030, 0, 3'b011, 32'hA5000030);
        add(5'b00110, 12'h007, 12'h030, 0, 4'b0110, 12'h030, 0, 3'b011, 32'hA5000030);
        add(5'b00110, 12'h007, 12'h030, 0, 4'b1010, 12'h030, 0, 3'b011, 32'hA5000030);
        add(5'b00110, 12'h007, 12'h030, 0, 4'b0110, 12'h007, 0, 3'b011, 32'hA5000030);
        add(5'b00110, 12'h007, 12'h030, 0, 4'b0110, 12'h030, 0, 3'b101, 32'hA5000007);
        add(5'b00110, 12'h007, 12'h030, 0, 4'b0110, 12'h030, 0, 3'b011, 32'hA5000030);
        add(5'b00110, 12'h007, 12'h030, 0, 4'b0110, 12'h030, 0, 3'b011, 32'hA5000030);
        add(5'b00110, 12'h007, 12'h030, 0, 4'b1010, 12'h030, 0, 3'b011, 32'hA5000030);
        add(5'b00000, 12'h000, 12'h000, 0, 4'b0010, 12'h007, 0, 3'b011, 32'hA5000030);
        add(5'b00000, 12'h000, 12'h000, 0, 4'b0000, 0,       0, 3'b101, 32'hA5000007);
        add(5'b00000, 12'h000, 12'h000, 0, 4'b0000, 0,       0, 3'b000, 0);
        // Data write beats fetch, fetch follows, then readback of the written word
        add(5'b00111, 12'h001, 12'h010, 32'h12345678, 4'b0100, 0, 0, 3'b000, 0);
        add(5'b00100, 12'h001, 12'h000, 0, 4'b1011, 12'h010, 32'h12345678, 3'b001, 0);
        add(5'b00000, 12'h000, 12'h000, 0, 4'b0010, 12'h001, 0, 3'b001, 0);
        add(5'b00000, 12'h000, 12'h000, 0, 4'b0000, 0,       0, 3'b101, 32'hA5000001);
        add(5'b00010, 12'h000, 12'h010, 0, 4'b0100, 0,       0, 3'b000, 0);
        add(5'b00000, 12'h000, 12'h000, 0, 4'b0010, 12'h010, 0, 3'b001, 0);
        add(5'b00000, 12'h000, 12'h000, 0, 4'b0000, 0,       0, 3'b011, 32'h12345678);
        add(5'b00000, 12'h000, 12'h000, 0, 4'b0000, 0,       0, 3'b000, 0);

        for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

        // Hold raised the cycle after a data read grant
        set_in(1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 12'h040, 32'h0);
        @(negedge clk);
        chk("hold.pre_d_gnt", 32'(d_gnt), 1);
        chk("hold.pre_if_gnt", 32'(if_gnt), 0);
        $display("hold: d read 0x040 granted=%b", d_gnt);
        tick();
        set_in(1'b0, 1'b1, 1'b1, 12'h002, 1'b1, 1'b0, 12'h041, 32'h0);
        @(negedge clk);
        chk("hold.h1_d_gnt", 32'(d_gnt), 0);
        chk("hold.h1_if_gnt", 32'(if_gnt), 0);
        chk("hold.h1_mem_en", 32'(mem_en), 1);
        chk("hold.h1_mem_addr", 32'(mem_addr), 32'h040);
        $display("hold: cycle 1 mem_en=%b addr=%03h gnt if/d=%b%b", mem_en, mem_addr, if_gnt, d_gnt);
        tick();
        @(negedge clk);
        chk("hold.h2_d_gnt", 32'(d_gnt), 0);
        chk("hold.h2_if_gnt", 32'(if_gnt), 0);
        chk("hold.h2_mem_en", 32'(mem_en), 0);
        chk("hold.h2_d_valid", 32'(d_valid), 1);
        chk("hold.h2_d_rdata", d_rdata, 32'hA5000040);
        chk("hold.h2_busy", 32'(busy), 1);
        $display("hold: cycle 2 d_valid=%b d_rdata=%08h", d_valid, d_rdata);
        tick();
        hold = 1'b0;
        @(negedge clk);
        chk("hold.rel_d_gnt", 32'(d_gnt), 1);
        chk("hold.rel_if_gnt", 32'(if_gnt), 0);
        chk("hold.rel_d_valid", 32'(d_valid), 0);
        $display("hold: released, gnt if/d=%b%b", if_gnt, d_gnt);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 32'h0);
        @(negedge clk);
        chk("hold.post_mem_en", 32'(mem_en), 1);
        chk("hold.post_mem_addr", 32'(mem_addr), 32'h041);
        tick();
        @(negedge clk);
        chk("hold.post_d_valid", 32'(d_valid), 1);
        chk("hold.post_d_rdata", d_rdata, 32'hA5000041);
        chk("hold.post_if_valid", 32'(if_valid), 0);
        $display("hold: resumed read d_rdata=%08h", d_rdata);
        tick();

        // Reset during the issue cycle of a fetch read
        set_in(1'b0, 1'b0, 1'b1, 12'h003, 1'b0, 1'b0, 12'h000, 32'h0);
        @(negedge clk);
        chk("rst.if_gnt", 32'(if_gnt), 1);
        tick();
        set_in(1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 12'h020, 32'h0);
        @(negedge clk);
        chk("rst.r_mem_en", 32'(mem_en), 1);
        chk("rst.r_d_gnt", 32'(d_gnt), 0);
        chk("rst.r_if_gnt", 32'(if_gnt), 0);
        $display("rst: asserted with mem_en=%b d_gnt=%b", mem_en, d_gnt);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 32'h0);
        @(negedge clk);
        chk("rst.a_if_valid", 32'(if_valid), 0);
        chk("rst.a_d_valid", 32'(d_valid), 0);
        chk("rst.a_mem_en", 32'(mem_en), 0);
        chk("rst.a_mem_we", 32'(mem_we), 0);
        chk("rst.a_mem_addr", 32'(mem_addr), 0);
        chk("rst.a_mem_wdata", mem_wdata, 0);
        chk("rst.a_busy", 32'(busy), 0);
        $display("rst: after reset if_valid=%b mem_en=%b busy=%b", if_valid, mem_en, busy);
        tick();
        @(negedge clk);
        chk("rst.b_if_valid", 32'(if_valid), 0);
        chk("rst.b_busy", 32'(busy), 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
